// File: rtl/gtp_sum_pkg.sv
// Shared widths, frame FSM state encoding, word tags and the saturating adder
// used by the gtp_nibble_sum frame-sum pipeline.
package gtp_sum_pkg;

  localparam int unsigned NIB_W      = 4;
  localparam int unsigned PAIR_SUM_W = 5;
  localparam int unsigned WORD_SUM_W = 6;
  localparam int unsigned SUM_EXT_W  = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } frame_state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } word_tag_t;

  typedef struct packed {
    logic                 ovf;
    logic [SUM_EXT_W-1:0] sum;
  } sat_sum_t;

  // Adds a word sum into an accumulator of 'width' bits, clamping at 2^width-1.
  function automatic sat_sum_t sat_add(input logic [SUM_EXT_W-1:0]  acc,
                                       input logic [WORD_SUM_W-1:0] addend,
                                       input int unsigned           width);
    logic [SUM_EXT_W:0] s;
    logic [SUM_EXT_W:0] lim;
    sat_sum_t           r;
    s   = {1'b0, acc} + (SUM_EXT_W+1)'(addend);
    lim = ((SUM_EXT_W+1)'(1) << width) - (SUM_EXT_W+1)'(1);
    if (s > lim) begin
      r.ovf = 1'b1;
      r.sum = lim[SUM_EXT_W-1:0];
    end else begin
      r.ovf = 1'b0;
      r.sum = s[SUM_EXT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_ROM.sv
// Nibble-pair adder lookup: address {a,b} returns a+b, asynchronous read.
module adder_ROM (
  input  logic [7:0] addr,
  output logic [4:0] data
);

  always_comb begin
    data = {1'b0, addr[7:4]} + {1'b0, addr[3:0]};
  end

endmodule

// File: rtl/gtp_sum_frame_fsm.sv
// Stage-0 frame tracker: counts accepted words, tags first/last words and
// flags frames aborted by an early start-of-frame.
module gtp_sum_frame_fsm
  import gtp_sum_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 8
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      i_valid,
  input  logic      i_sof,
  output word_tag_t o_tag,
  output logic      o_frame_err
);

  localparam logic [7:0] CNT_LAST = 8'(FRAME_LEN - 1);

  frame_state_t r_state;
  logic [7:0]   r_count;
  logic         r_frame_err;
  word_tag_t    w_tag;

  // Tags are decoded combinationally so the word enters stage 1 in the same cycle.
  always_comb begin
    w_tag = '0;
    if (i_valid) begin
      if (i_sof) begin
        w_tag.valid = 1'b1;
        w_tag.first = 1'b1;
      end else if (r_state == ACCUM) begin
        w_tag.valid = 1'b1;
        w_tag.last  = (r_count == CNT_LAST);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= i_valid & i_sof & (r_state == ACCUM);
      if (i_valid) begin
        if (i_sof) begin
          r_state <= ACCUM;
          r_count <= 8'd1;
        end else if (r_state == ACCUM) begin
          if (r_count == CNT_LAST) begin
            r_state <= IDLE;
            r_count <= '0;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
      end
    end
  end

  assign o_tag       = w_tag;
  assign o_frame_err = r_frame_err;

endmodule

// File: rtl/gtp_nibble_sum.sv
// Per-frame nibble sum of GTP receive words: 3-stage pipeline + saturating accumulator.
// Optional threshold output trig enabled by GTP_NIBBLE_SUM_THRESH_CMP_EN.
module gtp_nibble_sum
  import gtp_sum_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned ACC_W     = 12,
  parameter int unsigned THRESH    = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic [ACC_W-1:0] frame_sum,
  output logic             out_valid,
  output logic             sat,
  output logic             frame_err
`ifdef GTP_NIBBLE_SUM_THRESH_CMP_EN
  ,
  output logic             trig
`endif
);

  word_tag_t               w_tag0;
  logic [PAIR_SUM_W-1:0]   w_s_hi;
  logic [PAIR_SUM_W-1:0]   w_s_lo;

  gtp_sum_frame_fsm #(.FRAME_LEN(FRAME_LEN)) u_fsm (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (in_valid),
    .i_sof       (in_sof),
    .o_tag       (w_tag0),
    .o_frame_err (frame_err)
  );

  adder_ROM u_rom_hi (.addr(in_data[15:8]), .data(w_s_hi));
  adder_ROM u_rom_lo (.addr(in_data[7:0]),  .data(w_s_lo));

  logic [PAIR_SUM_W-1:0] r_s1_hi;
  logic [PAIR_SUM_W-1:0] r_s1_lo;
  word_tag_t             r_s1_tag;
  logic [WORD_SUM_W-1:0] r_s2_sum;
  word_tag_t             r_s2_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_hi  <= '0;
      r_s1_lo  <= '0;
      r_s1_tag <= '0;
      r_s2_sum <= '0;
      r_s2_tag <= '0;
    end else begin
      r_s1_hi  <= w_s_hi;
      r_s1_lo  <= w_s_lo;
      r_s1_tag <= w_tag0;
      r_s2_sum <= {1'b0, r_s1_hi} + {1'b0, r_s1_lo};
      r_s2_tag <= r_s1_tag;
    end
  end

  logic [ACC_W-1:0] r_acc;
  logic             r_acc_sat;
  logic [ACC_W-1:0] r_frame_sum;
  logic             r_out_valid;
  logic             r_sat;
  sat_sum_t         w_add;
  logic [ACC_W-1:0] w_acc_next;
  logic             w_sat_next;
  logic             w_unused_sum;

  always_comb begin
    w_add = sat_add(16'(r_acc), r_s2_sum, ACC_W);
    if (r_s2_tag.first) begin
      w_acc_next = ACC_W'(r_s2_sum);
      w_sat_next = 1'b0;
    end else begin
      w_acc_next = w_add.sum[ACC_W-1:0];
      w_sat_next = r_acc_sat | w_add.ovf;
    end
  end

  // Bits above ACC_W are always zero after clamping.
  assign w_unused_sum = ^w_add.sum;

`ifdef GTP_NIBBLE_SUM_THRESH_CMP_EN
  logic r_trig;
  logic w_trig_next;
  assign w_trig_next = w_sat_next | (32'(w_acc_next) >= THRESH);
`else
  localparam int unsigned unused_thresh = THRESH;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_acc_sat   <= 1'b0;
      r_frame_sum <= '0;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
`ifdef GTP_NIBBLE_SUM_THRESH_CMP_EN
      r_trig      <= 1'b0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      if (r_s2_tag.valid) begin
        r_acc     <= w_acc_next;
        r_acc_sat <= w_sat_next;
        if (r_s2_tag.last) begin
          r_frame_sum <= w_acc_next;
          r_sat       <= w_sat_next;
          r_out_valid <= 1'b1;
`ifdef GTP_NIBBLE_SUM_THRESH_CMP_EN
          r_trig      <= w_trig_next;
`endif
        end
      end
    end
  end

  assign frame_sum = r_frame_sum;
  assign out_valid = r_out_valid;
  assign sat       = r_sat;
`ifdef GTP_NIBBLE_SUM_THRESH_CMP_EN
  assign trig      = r_trig;
`endif

endmodule

// File: tb/tb_gtp_nibble_sum.sv
// Bench for gtp_nibble_sum: a 12-bit and an 8-bit accumulator instance driven in
// parallel, checked every cycle against a frame-level arithmetic model.
module tb_gtp_nibble_sum;

  localparam int LEN   = 8;
  localparam int MAX12 = 4095;
  localparam int MAX8  = 255;
  localparam int THR   = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_sof;
  logic [11:0] fs12;
  logic        ov12, sat12, fe12;
  logic [7:0]  fs8;
  logic        ov8, sat8, fe8;
`ifdef GTP_NIBBLE_SUM_THRESH_CMP_EN
  logic        trig12, trig8;
`endif

  always #5 clk = ~clk;

  gtp_nibble_sum #(.FRAME_LEN(LEN), .ACC_W(12), .THRESH(THR)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .frame_sum(fs12), .out_valid(ov12), .sat(sat12), .frame_err(fe12)
`ifdef GTP_NIBBLE_SUM_THRESH_CMP_EN
    , .trig(trig12)
`endif
  );

  gtp_nibble_sum #(.FRAME_LEN(LEN), .ACC_W(8), .THRESH(THR)) u_dut8 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
    .frame_sum(fs8), .out_valid(ov8), .sat(sat8), .frame_err(fe8)
`ifdef GTP_NIBBLE_SUM_THRESH_CMP_EN
    , .trig(trig8)
`endif
  );

  // Frame-level model: completed frame sums appear two edges after the last word's edge.
  typedef struct {
    int due;
    int sum;
  } ev_t;
  ev_t pend[$];

  int edge_n = 0;
  bit in_frame = 1'b0;
  int nwords = 0;
  int run_sum = 0;
  int exp_fs12 = 0, exp_fs8 = 0;
  bit exp_ov = 1'b0, exp_fe = 1'b0, exp_sat12 = 1'b0, exp_sat8 = 1'b0;
  bit exp_trig12 = 1'b0, exp_trig8 = 1'b0;
  bit chk_en = 1'b0;

  int total = 0;
  int bad = 0;
  int ov_cnt = 0;
  int fe_cnt = 0;

  function automatic int word_sum(input logic [15:0] d);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'(d[4*i +: 4]);
    return s;
  endfunction

  initial forever begin
    @(posedge clk);
    edge_n++;
    exp_ov = 1'b0;
    exp_fe = 1'b0;
    if (rst) begin
      in_frame = 1'b0;
      nwords = 0;
      run_sum = 0;
      pend.delete();
      exp_fs12 = 0; exp_fs8 = 0;
      exp_sat12 = 1'b0; exp_sat8 = 1'b0;
      exp_trig12 = 1'b0; exp_trig8 = 1'b0;
      chk_en = 1'b1;
    end else begin
      if (pend.size() != 0 && pend[0].due == edge_n) begin
        ev_t p;
        p = pend.pop_front();
        exp_ov     = 1'b1;
        exp_sat12  = (p.sum > MAX12);
        exp_sat8   = (p.sum > MAX8);
        exp_fs12   = exp_sat12 ? MAX12 : p.sum;
        exp_fs8    = exp_sat8 ? MAX8 : p.sum;
        exp_trig12 = exp_sat12 || (exp_fs12 >= THR);
        exp_trig8  = exp_sat8 || (exp_fs8 >= THR);
      end
      if (in_valid) begin
        if (in_sof) begin
          if (in_frame) exp_fe = 1'b1;
          in_frame = 1'b1;
          nwords = 1;
          run_sum = word_sum(in_data);
        end else if (in_frame) begin
          nwords++;
          run_sum += word_sum(in_data);
          if (nwords == LEN) begin
            pend.push_back('{edge_n + 2, run_sum});
            in_frame = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    if (chk_en) begin
      chk("fs12",  int'(fs12),  exp_fs12);
      chk("ov12",  int'(ov12),  int'(exp_ov));
      chk("sat12", int'(sat12), int'(exp_sat12));
      chk("fe12",  int'(fe12),  int'(exp_fe));
      chk("fs8",   int'(fs8),   exp_fs8);
      chk("ov8",   int'(ov8),   int'(exp_ov));
      chk("sat8",  int'(sat8),  int'(exp_sat8));
      chk("fe8",   int'(fe8),   int'(exp_fe));
`ifdef GTP_NIBBLE_SUM_THRESH_CMP_EN
      chk("trig12", int'(trig12), int'(exp_trig12));
      chk("trig8",  int'(trig8),  int'(exp_trig8));
`endif
    end
    ov_cnt += int'(ov12);
    fe_cnt += int'(fe12);
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_all();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [15:0] d, input bit sof);
    tick();
    in_data  = d;
    in_valid = 1'b1;
    in_sof   = sof;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      in_data  = '0;
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] d, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      word(d, i == 0);
      if (gaps) idle(i % 4);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    int ov0, fe0, lat;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_sof = 1'b0;
    idle(3);
    tick();
    rst = 1'b0;
    chk("reset_fs",  int'(fs12), 0);
    chk("reset_ov",  int'(ov12), 0);
    chk("reset_fe",  int'(fe12), 0);

    // Words without start-of-frame are ignored
    ov0 = ov_cnt;
    for (int i = 0; i < 5; i++) word(16'h1234, 1'b0);
    idle(6);
    chk("nosof_ov", ov_cnt - ov0, 0);
    chk("nosof_fs", int'(fs12), 0);

    // 0x1111 x8 with latency measurement
    for (int i = 0; i < LEN; i++) word(16'h1111, i == 0);
    lat = 11;
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      if (ov12) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, 3);
    idle(4);
    chk("fs_1111", int'(fs12), 32);
    chk("sat_1111", int'(sat12), 0);

    frame(16'hFFFF, LEN, 1'b0);
    idle(6);
    chk("fs_ffff_12", int'(fs12), 480);
    chk("sat_ffff_12", int'(sat12), 0);
    chk("fs_ffff_8", int'(fs8), 255);
    chk("sat_ffff_8", int'(sat8), 1);

    ov0 = ov_cnt;
    frame(16'h1111, LEN, 1'b1);
    idle(6);
    chk("gaps_fs", int'(fs12), 32);
    chk("gaps_ov", ov_cnt - ov0, 1);

    ov0 = ov_cnt; fe0 = fe_cnt;
    for (int i = 0; i < 3; i++) word(16'h2222, i == 0);
    frame(16'h0001, LEN, 1'b0);
    idle(6);
    chk("abort_fe", fe_cnt - fe0, 1);
    chk("abort_ov", ov_cnt - ov0, 1);
    chk("abort_fs", int'(fs12), 8);

    ov0 = ov_cnt;
    frame(16'h1111, LEN, 1'b0);
    frame(16'h0101, LEN, 1'b0);
    idle(6);
    chk("b2b_ov", ov_cnt - ov0, 2);
    chk("b2b_fs", int'(fs12), 16);

    // Reset after the fifth word discards the partial frame
    ov0 = ov_cnt;
    for (int i = 0; i < 5; i++) word(16'h3333, i == 0);
    tick();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    idle(2);
    tick();
    rst = 1'b0;
    idle(6);
    chk("rstmid_ov", ov_cnt - ov0, 0);
    chk("rstmid_fs", int'(fs12), 0);
    chk("rstmid_sat8", int'(sat8), 0);
    frame(16'h1111, LEN, 1'b0);
    idle(6);
    chk("after_rst_fs", int'(fs12), 32);

    frame(16'h3333, LEN, 1'b0);
    idle(6);
    chk("fs_3333", int'(fs12), 96);
`ifdef GTP_NIBBLE_SUM_THRESH_CMP_EN
    chk("trig_3333", int'(trig12), 0);
`endif
    frame(16'h4444, LEN, 1'b0);
    idle(6);
    chk("fs_4444", int'(fs12), 128);
`ifdef GTP_NIBBLE_SUM_THRESH_CMP_EN
    chk("trig_4444", int'(trig12), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
